// File: rtl/seg_capture.sv
// rtl/seg_capture.sv - captures a multiplexed active-low 7-segment display into four hex digits
module seg_capture #(
    parameter int SETTLE = 4,
    parameter int STABLE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic [3:0] an,
    output logic [3:0] dis0,
    output logic [3:0] dis1,
    output logic [3:0] dis2,
    output logic [3:0] dis3,
    output logic [3:0] dvalid,
    output logic       frame_done,
    output logic       err
);

    localparam int MAXC = (SETTLE > STABLE) ? SETTLE : STABLE;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(MAXC);
    localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE - 1);
    localparam logic [CW-1:0] STABLE_END = CW'(STABLE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_HOLD} state_t;

    state_t        state, state_n;
    logic [6:0]    seg_m, seg_s;
    logic [3:0]    an_m, an_s;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [6:0]    refv, refv_n;
    logic [3:0]    cur_an, cur_an_n;
    logic [1:0]    pos, pos_n, an_idx;
    logic          an_one, an_none, wr, err_set;
    logic [3:0]    dec_val;
    logic          dec_legal;
    logic [3:0]    seen, wmask;
    logic [3:0]    dis_r [4];

    assign dis0 = dis_r[0];
    assign dis1 = dis_r[1];
    assign dis2 = dis_r[2];
    assign dis3 = dis_r[3];

    // Two-flop synchronizer on the display bus; idle level (all ones) out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_m <= 7'h7F;
            seg_s <= 7'h7F;
            an_m  <= 4'hF;
            an_s  <= 4'hF;
        end else begin
            seg_m <= seg;
            seg_s <= seg_m;
            an_m  <= an;
            an_s  <= an_m;
        end
    end

    // Classify the synchronized anodes: exactly one low, none low, or several low
    always_comb begin
        an_one  = 1'b1;
        an_none = 1'b0;
        an_idx  = 2'd0;
        case (an_s)
            4'b1110: an_idx = 2'd0;
            4'b1101: an_idx = 2'd1;
            4'b1011: an_idx = 2'd2;
            4'b0111: an_idx = 2'd3;
            4'b1111: begin an_one = 1'b0; an_none = 1'b1; end
            default: an_one = 1'b0;
        endcase
    end

    // Glyph decode of the reference sample (equal to seg_s whenever a write fires)
    always_comb begin
        dec_legal = 1'b1;
        dec_val   = 4'h0;
        case (refv)
            7'b1000000: dec_val = 4'h0;
            7'b1111001: dec_val = 4'h1;
            7'b0100100: dec_val = 4'h2;
            7'b0110000: dec_val = 4'h3;
            7'b0011001: dec_val = 4'h4;
            7'b0010010: dec_val = 4'h5;
            7'b0000010: dec_val = 4'h6;
            7'b1111000: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0010000: dec_val = 4'h9;
            7'b0001000: dec_val = 4'hA;
            7'b0000011: dec_val = 4'hB;
            7'b1000110: dec_val = 4'hC;
            7'b0100001: dec_val = 4'hD;
            7'b0000110: dec_val = 4'hE;
            7'b0001110: dec_val = 4'hF;
            default:    dec_legal = 1'b0;
        endcase
    end

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    // Next-state logic: anode changes override every state, then per-state settle/sample/hold
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        refv_n   = refv;
        cur_an_n = cur_an;
        pos_n    = pos;
        wr       = 1'b0;
        err_set  = 1'b0;
        if (!an_one && !an_none) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            err_set = 1'b1;
        end else if (an_none) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else if (state == ST_IDLE || an_s != cur_an) begin
            state_n  = ST_SETTLE;
            cur_an_n = an_s;
            pos_n    = an_idx;
            cnt_n    = '0;
        end else begin
            case (state)
                ST_SETTLE: begin
                    if (cnt == SETTLE_END) begin
                        state_n = ST_SAMPLE;
                        cnt_n   = '0;
                        refv_n  = seg_s;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                ST_SAMPLE: begin
                    if (seg_s == refv) begin
                        if (cnt == STABLE_END) begin
                            wr      = 1'b1;
                            state_n = ST_HOLD;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        cnt_n  = '0;
                        refv_n = seg_s;
                    end
                end
                default: ;
            endcase
        end
    end

    // Capture FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            refv   <= 7'h7F;
            cur_an <= 4'hF;
            pos    <= 2'd0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            refv   <= refv_n;
            cur_an <= cur_an_n;
            pos    <= pos_n;
        end
    end

    assign wmask = wr ? (4'b0001 << pos) : 4'b0000;

    // Digit writes, sticky error, and frame completion tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) dis_r[i] <= 4'h0;
            dvalid     <= 4'h0;
            err        <= 1'b0;
            seen       <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            if (err_set || (wr && !dec_legal && refv != 7'h7F)) err <= 1'b1;
            if (wr) begin
                if (dec_legal) begin
                    dis_r[pos]  <= dec_val;
                    dvalid[pos] <= 1'b1;
                end else begin
                    dvalid[pos] <= 1'b0;
                end
            end
            if (seen == 4'hF) begin
                frame_done <= 1'b1;
                seen       <= wmask;
            end else begin
                frame_done <= 1'b0;
                seen       <= seen | wmask;
            end
        end
    end

endmodule

// File: tb/tb_seg_capture.sv
// tb/tb_seg_capture.sv - randomized and directed bench for seg_capture with a behavioural model
module tb_seg_capture;

    localparam int SETTLE = 4;
    localparam int STABLE = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] seg = 7'h7F;
    logic [3:0] an  = 4'hF;
    logic [3:0] dis0, dis1, dis2, dis3, dvalid;
    logic       frame_done, err;

    seg_capture #(.SETTLE(SETTLE), .STABLE(STABLE)) dut (
        .clk(clk), .rst(rst), .seg(seg), .an(an),
        .dis0(dis0), .dis1(dis1), .dis2(dis2), .dis3(dis3),
        .dvalid(dvalid), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] glyph [16];

    // reference model state
    logic [6:0] s1_seg, s2_seg;
    logic [3:0] s1_an, s2_an;
    int         run;
    logic [3:0] cur_an;
    logic [6:0] hist [$];
    bit         written;
    logic [3:0] m_dis [4];
    logic [3:0] m_dvalid;
    logic       m_err, m_fd;
    logic [3:0] m_seen;
    int         fd_pulses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        s1_seg = 7'h7F; s2_seg = 7'h7F; s1_an = 4'hF; s2_an = 4'hF;
        run = -1; written = 0; hist.delete(); cur_an = 4'hF;
        for (int i = 0; i < 4; i++) m_dis[i] = 4'h0;
        m_dvalid = 4'h0; m_err = 1'b0; m_fd = 1'b0; m_seen = 4'h0;
    endtask

    task automatic model_capture(input logic [6:0] g, input int p);
        int found;
        found = -1;
        for (int i = 0; i < 16; i++) if (glyph[i] == g) found = i;
        if (found >= 0) begin
            m_dis[p] = 4'(found);
            m_dvalid[p] = 1'b1;
        end else begin
            m_dvalid[p] = 1'b0;
            if (g != 7'h7F) m_err = 1'b1;
        end
    endtask

    // One clock edge of the model: synced inputs lag the driven ones by two edges;
    // a digit is taken once the anode has been steady SETTLE edges and the following
    // STABLE+1 synced samples are identical.
    task automatic model_edge();
        logic [6:0] g;
        logic [3:0] a, wm;
        int lows, p;
        bit same;
        g = s2_seg; a = s2_an;
        s2_seg = s1_seg; s2_an = s1_an;
        s1_seg = seg;    s1_an = an;
        wm = 4'h0;
        lows = 4 - $countones(a);
        if (lows > 1) begin
            m_err = 1'b1;
            run = -1;
        end else if (lows == 0) begin
            run = -1;
        end else begin
            if (run < 0 || a != cur_an) begin
                cur_an = a; run = 0; written = 0; hist.delete();
            end else begin
                run++;
            end
            if (run >= SETTLE && !written) begin
                hist.push_back(g);
                if (hist.size() >= STABLE + 1) begin
                    same = 1;
                    for (int i = hist.size() - STABLE - 1; i < hist.size(); i++)
                        if (hist[i] != g) same = 0;
                    if (same) begin
                        written = 1;
                        p = 0;
                        for (int i = 0; i < 4; i++) if (!a[i]) p = i;
                        model_capture(g, p);
                        wm[p] = 1'b1;
                    end
                end
            end
        end
        if (m_seen == 4'hF) begin
            m_fd = 1'b1; m_seen = wm;
        end else begin
            m_fd = 1'b0; m_seen = m_seen | wm;
        end
    endtask

    task automatic compare_all();
        check("dis0", dis0, m_dis[0]);
        check("dis1", dis1, m_dis[1]);
        check("dis2", dis2, m_dis[2]);
        check("dis3", dis3, m_dis[3]);
        check("dvalid", dvalid, m_dvalid);
        check("err", err, m_err);
        check("frame_done", frame_done, m_fd);
    endtask

    task automatic step(input logic [6:0] sg, input logic [3:0] a);
        seg = sg; an = a;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (frame_done === 1'b1) fd_pulses++;
    endtask

    task automatic hold_digit(input int p, input logic [6:0] sg, input int cycles);
        logic [3:0] a;
        a = ~(4'b0001 << p);
        for (int i = 0; i < cycles; i++) step(sg, a);
    endtask

    task automatic scan_1234();
        hold_digit(0, glyph[4], 32);
        hold_digit(1, glyph[3], 32);
        hold_digit(2, glyph[2], 32);
        hold_digit(3, glyph[1], 32);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int lat;
        logic [6:0] sg;
        glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
        glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
        glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
        glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;
        fd_pulses = 0;

        // reset state
        model_reset();
        #1;
        compare_all();
        @(posedge clk); #1; compare_all();
        @(posedge clk); #1; compare_all();
        rst = 1'b1;

        // two full scans of "1234"
        scan_1234();
        scan_1234();
        check("scan_dis0", dis0, 4'h4);
        check("scan_dis1", dis1, 4'h3);
        check("scan_dis2", dis2, 4'h2);
        check("scan_dis3", dis3, 4'h1);
        check("scan_dvalid", dvalid, 4'hF);
        check("scan_err", err, 1'b0);
        check("scan_fd_pulses", fd_pulses, 2);

        // hold one short of the capture window, then exactly the window
        hold_digit(0, glyph[9], SETTLE + STABLE - 1);
        hold_digit(1, glyph[3], 2);
        check("short_hold_dis0", dis0, 4'h4);
        hold_digit(1, glyph[3], 30);
        hold_digit(0, glyph[9], SETTLE + STABLE + 1);
        hold_digit(1, glyph[3], 4);
        check("exact_hold_dis0", dis0, 4'h9);
        hold_digit(1, glyph[3], 28);

        // blank digit: holds value, invalid, no error
        hold_digit(0, 7'h7F, 32);
        check("blank_dvalid0", dvalid[0], 1'b0);
        check("blank_dis0", dis0, 4'h9);
        check("blank_err", err, 1'b0);

        // two anodes low: sticky error, no write
        pulse_reset();
        scan_1234();
        for (int i = 0; i < 20; i++) step(glyph[8], 4'b1100);
        check("multi_err", err, 1'b1);
        check("multi_dis0", dis0, 4'h4);
        check("multi_dis1", dis1, 4'h3);

        // seg toggling during sampling: write STABLE edges after the last synced change
        pulse_reset();
        for (int i = 0; i < 24; i++) step(((i / 3) % 2) ? glyph[6] : glyph[5], 4'b1110);
        check("toggle_nowrite", dvalid[0], 1'b0);
        step(glyph[7], 4'b1110);
        lat = -1;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            step(glyph[7], 4'b1110);
            if (dis0 === 4'h7) lat = i;
        end
        check("toggle_latency", lat, 2 + STABLE);

        // reset while sampling digit 2 aborts the capture
        scan_1234();
        for (int i = 0; i < 9; i++) step(glyph[6], 4'b1011);
        pulse_reset();
        check("rst_dis2", dis2, 4'h0);
        check("rst_dvalid", dvalid, 4'h0);
        hold_digit(2, glyph[6], 32);

        // randomized scans with random holds, blanks, junk and idle gaps
        for (int n = 0; n < 60; n++) begin
            int p, r;
            p = $urandom_range(0, 3);
            r = $urandom_range(0, 15);
            sg = glyph[$urandom_range(0, 15)];
            if (r == 0) sg = 7'h7F;
            else if (r == 1) sg = 7'($urandom);
            if (r == 2) begin
                for (int i = 0; i < 6; i++) step(sg, 4'hF);
            end else begin
                hold_digit(p, sg, $urandom_range(8, 34));
            end
        end

        // illegal glyph sets sticky error that survives legal scans
        pulse_reset();
        hold_digit(0, 7'b0101010, 32);
        check("illegal_dvalid0", dvalid[0], 1'b0);
        check("illegal_err", err, 1'b1);
        scan_1234();
        scan_1234();
        check("sticky_err", err, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter SETTLE, 4, cycles ignored after each anode change before sampling starts.
REQ-002 Parameter STABLE, 8, consecutive identical synchronized seg samples required to accept a digit.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 seg  input  7  multiplexed segment bus, active-low, bit0=a .. bit6=g.
REQ-006 an  input  4  digit anodes, active-low, an[0]=rightmost digit.
REQ-007 dis0, dis1, dis2, dis3  output  4 each  last decoded hex value per digit position.
REQ-008 dvalid  output  4  per-digit flag: last capture of that position was a legal glyph.
REQ-009 frame_done  output  1  one-cycle pulse when all four positions have been captured since the previous pulse.
REQ-010 err  output  1  sticky error flag: illegal glyph or more than one anode low.

Function
REQ-011 seg and an SHALL pass through a two-flop synchronizer; every later timing is counted from the synchronized values.
REQ-012 FSM states: IDLE, SETTLE, SAMPLE, HOLD.
REQ-013 IDLE: exactly one an bit low -> SETTLE, latch the active position, clear the counter; an=4'hF -> stay in IDLE; two or more bits low -> stay in IDLE and set err.
REQ-014 SETTLE: count SETTLE cycles -> SAMPLE, counter cleared, current seg registered as the reference sample.
REQ-015 SAMPLE: seg equals the reference -> counter+1; seg differs -> counter=0 and the reference reloads.
REQ-016 SAMPLE: counter reaches STABLE-1 with an equal seg -> decode, write the digit, go to HOLD.
REQ-017 In any state, an change to a different one-hot-low value -> SETTLE with the new position; an=4'hF -> IDLE; multiple lows -> IDLE and set err.
REQ-018 HOLD: no further write until an changes; an unchanged -> remain.
REQ-019 Decode table (seg, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 Legal glyph: dis[pos] gets the value and dvalid[pos]=1.
REQ-021 Blank (7'h7F) or any other pattern: dis[pos] holds, dvalid[pos]=0; any pattern other than blank also sets err.
REQ-022 Every capture, legal or not, sets seen[pos] (internal, 4 bits).
REQ-023 seen reaching 4'hF: frame_done=1 for exactly one cycle, registered, in the cycle after the completing write; seen clears to 0 that same cycle.
REQ-024 A capture landing in the same cycle seen clears: that position counts toward the new frame.
REQ-025 Latency, in clk cycles, from the first synchronized stable seg after settle to dis update: STABLE.
REQ-026 Counter width SHALL hold max(SETTLE, STABLE) without wrap; the counter saturates.
REQ-027 err clears only on reset.

Reset
REQ-028 While rst=0: state=IDLE, dis0-3=4'h0, dvalid=4'h0, frame_done=0, err=0, seen=0, counter=0, synchronizers=all ones.
REQ-029 Reset assertion mid-capture SHALL abort the capture with no write; after release, operation begins from IDLE.

Verification
REQ-030 Scan "1234" (an 1110,1101,1011,0111; seg 1..4 glyphs), 32 cycles per digit -> dis0=4, dis1=3, dis2=2, dis3=1, dvalid=4'hF, one frame_done pulse per full scan, err=0.
REQ-031 Digit held for only SETTLE+STABLE-1 synced cycles before an changes -> that position is not updated and not marked seen.
REQ-032 seg=7'b1111111 on an=1110 for 32 cycles -> dis0 holds its previous value, dvalid[0]=0, err=0; seg=7'b0101010 -> dvalid[0]=0, err=1, still 1 after further legal scans.
REQ-033 an=4'b1100 for 20 cycles -> err=1, no dis write, FSM in IDLE.
REQ-034 seg toggles every 3 cycles during SAMPLE, then stays steady -> write occurs exactly STABLE cycles after the last toggle.
REQ-035 rst=0 asserted for 1 cycle during SAMPLE of digit 2 -> all outputs reach their reset values immediately, with no write to dis2.
